// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 target exposing NREGS 8-bit registers.
// Frame: byte0 = {RW, ADDR[6:0]} (RW=1 write), byte1 = data, MSB first.
// SCLK/SS_n/MOSI are oversampled on Clk_i through 2-flop synchronizers.
// Optional feature macro: AUTO_INC_EN (streaming data bytes with address
// auto-increment instead of a single data byte per frame).
`timescale 1ns/1ps
module spi_reg_responder #(
  parameter int         NREGS  = 4,
  parameter logic [7:0] ID     = 8'hA5,
  parameter logic [7:0] RSTVAL = 8'h00
) (
  input  logic               Clk_i,
  input  logic               Rst_ni,
  input  logic               Sclk_i,
  input  logic               Ss_ni,
  input  logic               Mosi_i,
  output logic               Miso_o,
  output logic               MisoOe_o,
  output logic [8*NREGS-1:0] Regs_o,
  output logic               WrStb_o,
  output logic [6:0]         WrAddr_o,
  output logic               Err_o
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam logic [7:0] NREGS_L = 8'(NREGS);
  localparam logic [6:0] ID_ADDR = 7'h7F;

  state_t      state_reg, state_next;
  logic        sclk_meta, sclk_sync, sclk_prev;
  logic        ss_meta, ss_sync, ss_prev;
  logic        mosi_meta, mosi_sync;
  logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [6:0]  shift_out;
  logic        miso_bit;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic        err;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic [7:0]  byte_in;
  logic [7:0]  rd_data;
  logic        addr_ok;
  logic        rd_ok;
  logic        wr_en;
  logic [7:0]  regs [NREGS];

  // Synchronize the SPI pins. SS sync flops reset low so that a select
  // already asserted when reset is released does not look like a falling edge.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      ss_meta   <= 1'b0;
      ss_sync   <= 1'b0;
      ss_prev   <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= Sclk_i;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      ss_meta   <= Ss_ni;
      ss_sync   <= ss_meta;
      ss_prev   <= ss_sync;
      mosi_meta <= Mosi_i;
      mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign ss_fall   = ~ss_sync & ss_prev;
  assign ss_rise   = ss_sync & ~ss_prev;
  assign byte_in   = {shift_in, mosi_sync};
  assign addr_ok   = {1'b0, cmd_addr} < NREGS_L;
  assign rd_ok     = addr_ok | (cmd_addr == ID_ADDR);
  assign wr_en     = (state_reg == DATA) & ~ss_rise & sclk_rise & (bit_cnt == 3'd7)
                     & cmd_rw & addr_ok;

  // Read mux: register file, the ID location, or zero for unmapped addresses.
  always_comb begin
    rd_data = 8'h00;
    if (cmd_addr == ID_ADDR) rd_data = ID;
    for (int k = 0; k < NREGS; k++) begin
      if (cmd_addr == 7'(k)) rd_data = regs[k];
    end
  end

  // FSM state register.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM next state: SS rise always aborts back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ss_fall) state_next = CMD;
      CMD: begin
        if (ss_rise) state_next = IDLE;
        else if (sclk_rise && bit_cnt == 3'd7) state_next = DATA;
      end
      DATA: begin
        if (ss_rise) state_next = IDLE;
        else if (sclk_rise && bit_cnt == 3'd7) begin
`ifdef AUTO_INC_EN
          state_next = DATA;
`else
          state_next = DONE;
`endif
        end
      end
      DONE:    if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: MISO only carries data during the data phase.
  always_comb begin
    MisoOe_o = (state_reg != IDLE);
    Miso_o   = (state_reg == DATA) ? miso_bit : 1'b0;
  end

  // Bit-level datapath: sample MOSI on SCLK rise, shift MISO on SCLK fall.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      shift_out <= 7'd0;
      miso_bit  <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= 7'd0;
      err       <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 7'd0;
    end else begin
      wr_stb <= 1'b0;
      if (state_reg == IDLE) begin
        if (ss_fall) begin
          bit_cnt  <= 3'd0;
          miso_bit <= 1'b0;
          err      <= 1'b0;
        end
      end else if (ss_rise) begin
        bit_cnt  <= 3'd0;
        miso_bit <= 1'b0;
      end else if (state_reg != DONE) begin
        if (sclk_rise) begin
          shift_in <= byte_in[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state_reg == CMD) begin
              cmd_rw   <= byte_in[7];
              cmd_addr <= byte_in[6:0];
            end else begin
              if (cmd_rw) begin
                if (addr_ok) begin
                  wr_stb  <= 1'b1;
                  wr_addr <= cmd_addr;
                end else begin
                  err <= 1'b1;
                end
              end
`ifdef AUTO_INC_EN
              cmd_addr <= cmd_addr + 7'd1;
`endif
            end
          end
        end else if (sclk_fall && state_reg == DATA) begin
          if (bit_cnt == 3'd0) begin
            // First fall of a data byte: load read data so bit7 is ready.
            miso_bit  <= rd_data[7];
            shift_out <= rd_data[6:0];
            if (!cmd_rw && !rd_ok) err <= 1'b1;
          end else begin
            miso_bit  <= shift_out[6];
            shift_out <= {shift_out[5:0], 1'b0};
          end
        end
      end
    end
  end

  // Register file: updated on the last sampled bit of a valid write byte.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= RSTVAL;
    end else if (wr_en) begin
      for (int k = 0; k < NREGS; k++) begin
        if (cmd_addr == 7'(k)) regs[k] <= byte_in;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_flat
      assign Regs_o[8*gi +: 8] = regs[gi];
    end
  endgenerate

  assign WrStb_o  = wr_stb;
  assign WrAddr_o = wr_addr;
  assign Err_o    = err;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Testbench for spi_reg_responder: table of frames, hand-written corner
// sequences, and randomized write/read pairs against a register-array model.
`timescale 1ns/1ps
module tb_spi_reg_responder;

  localparam int NREGS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, wr_stb, err;
  logic [31:0] regs;
  logic [6:0]  wr_addr;

  always #5 clk = ~clk;

  spi_reg_responder #(.NREGS(NREGS), .ID(8'hA5), .RSTVAL(8'h00)) dut (
    .Clk_i   (clk),
    .Rst_ni  (rst_n),
    .Sclk_i  (sclk),
    .Ss_ni   (ss_n),
    .Mosi_i  (mosi),
    .Miso_o  (miso),
    .MisoOe_o(miso_oe),
    .Regs_o  (regs),
    .WrStb_o (wr_stb),
    .WrAddr_o(wr_addr),
    .Err_o   (err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         stb_cnt = 0;
  logic [6:0] last_wr_addr = 7'd0;
  logic [7:0] model_regs [NREGS];

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  dat;
    logic        chk_rx;
    logic [7:0]  exp_rx;
    logic        exp_err;
    int          exp_stb;
    logic [31:0] exp_regs;
  } vec_t;

  vec_t vecs [12];

  // Count every cycle WrStb_o is high; a stretched pulse counts twice.
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt++;
      last_wr_addr = wr_addr;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      wait_cyc(4);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      wait_cyc(4);
      sclk = 1'b0;
    end
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    wait_cyc(4);
  endtask

  task automatic ss_end();
    wait_cyc(4);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(6);
  endtask

  task automatic frame2(input logic [7:0] cmd, input logic [7:0] dat,
                        output logic [7:0] rx0, output logic [7:0] rx1);
    ss_begin();
    spi_bits(cmd, 8, rx0);
    spi_bits(dat, 8, rx1);
    ss_end();
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (int'(a) < NREGS) return model_regs[int'(a)];
    if (a == 7'h7F) return 8'hA5;
    return 8'h00;
  endfunction

  initial begin
    logic [7:0] r0, r1, r2;
    logic [6:0] a;
    logic [7:0] d;
    logic [31:0] flat;
    int stb0;
    vec_t v;

    //             cmd    dat   chk   rx     err   stb  regs {r3,r2,r1,r0}
    vecs[0]  = '{8'h82, 8'h3C, 1'b0, 8'h00, 1'b0, 1, 32'h003C0000};
    vecs[1]  = '{8'h02, 8'h00, 1'b1, 8'h3C, 1'b0, 0, 32'h003C0000};
    vecs[2]  = '{8'h7F, 8'h00, 1'b1, 8'hA5, 1'b0, 0, 32'h003C0000};
    vecs[3]  = '{8'h85, 8'hFF, 1'b0, 8'h00, 1'b1, 0, 32'h003C0000};
    vecs[4]  = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 0, 32'h003C0000};
    vecs[5]  = '{8'hFF, 8'h12, 1'b0, 8'h00, 1'b1, 0, 32'h003C0000};
    vecs[6]  = '{8'h05, 8'h00, 1'b1, 8'h00, 1'b1, 0, 32'h003C0000};
    vecs[7]  = '{8'h80, 8'hA1, 1'b0, 8'h00, 1'b0, 1, 32'h003C00A1};
    vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'hA1, 1'b0, 0, 32'h003C00A1};
    vecs[9]  = '{8'h83, 8'h7E, 1'b0, 8'h00, 1'b0, 1, 32'h7E3C00A1};
    vecs[10] = '{8'h03, 8'h00, 1'b1, 8'h7E, 1'b0, 0, 32'h7E3C00A1};
    vecs[11] = '{8'h40, 8'h00, 1'b1, 8'h00, 1'b1, 0, 32'h7E3C00A1};

    // Reset state
    wait_cyc(5);
    check("rst_regs", regs, 32'h0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wraddr", {25'd0, wr_addr}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(6);
    check("post_rst_oe", {31'd0, miso_oe}, 32'd0);
    check("post_rst_stb", stb_cnt, 0);
    $display("reset: regs=%h oe=%b err=%b", regs, miso_oe, err);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      stb0 = stb_cnt;
      frame2(v.cmd, v.dat, r0, r1);
      check($sformatf("v%0d_cmd_miso", i), {24'd0, r0}, 32'd0);
      if (v.chk_rx) check($sformatf("v%0d_rx", i), {24'd0, r1}, {24'd0, v.exp_rx});
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v.exp_err});
      check($sformatf("v%0d_stb", i), stb_cnt - stb0, v.exp_stb);
      check($sformatf("v%0d_regs", i), regs, v.exp_regs);
      check($sformatf("v%0d_oe", i), {31'd0, miso_oe}, 32'd0);
      if (v.exp_stb == 1)
        check($sformatf("v%0d_wraddr", i), {25'd0, last_wr_addr}, {25'd0, v.cmd[6:0]});
      $display("vec %0d: cmd=%h dat=%h rx=%h err=%b regs=%h", i, v.cmd, v.dat, r1, err, regs);
    end

    // Abort mid data byte: no write, no strobe, counter cleared for next frame
    stb0 = stb_cnt;
    ss_begin();
    spi_bits(8'h81, 8, r0);
    check("abort_oe_active", {31'd0, miso_oe}, 32'd1);
    spi_bits(8'hFF, 5, r1);
    ss_end();
    check("abort_reg1", {24'd0, regs[15:8]}, 32'h00);
    check("abort_stb", stb_cnt - stb0, 0);
    check("abort_oe", {31'd0, miso_oe}, 32'd0);
    frame2(8'h81, 8'h5A, r0, r1);
    frame2(8'h01, 8'h00, r0, r1);
    check("abort_recover_rx", {24'd0, r1}, 32'h5A);
    check("abort_recover_stb", stb_cnt - stb0, 1);
    $display("abort: regs=%h rx=%h", regs, r1);

`ifdef AUTO_INC_EN
    // Streaming write with address auto-increment
    stb0 = stb_cnt;
    ss_begin();
    spi_bits(8'h81, 8, r0);
    spi_bits(8'h11, 8, r1);
    spi_bits(8'h22, 8, r2);
    ss_end();
    check("auto_reg1", {24'd0, regs[15:8]}, 32'h11);
    check("auto_reg2", {24'd0, regs[23:16]}, 32'h22);
    check("auto_stb", stb_cnt - stb0, 2);
    $display("auto-inc: regs=%h", regs);
`else
    // Extra byte after the data byte is ignored and MISO stays low
    stb0 = stb_cnt;
    ss_begin();
    spi_bits(8'h82, 8, r0);
    spi_bits(8'h11, 8, r1);
    spi_bits(8'h99, 8, r2);
    ss_end();
    check("extra_reg2", {24'd0, regs[23:16]}, 32'h11);
    check("extra_reg3", {24'd0, regs[31:24]}, 32'h7E);
    check("extra_stb", stb_cnt - stb0, 1);
    check("extra_miso", {24'd0, r2}, 32'h00);
    $display("extra byte: regs=%h rx3=%h", regs, r2);
`endif

    // Reset mid-frame, with Err set by an invalid read
    stb0 = stb_cnt;
    ss_begin();
    spi_bits(8'h05, 8, r0);
    spi_bits(8'h00, 4, r1);
    check("prerst_err", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midrst_regs", regs, 32'h0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_wraddr", {25'd0, wr_addr}, 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(6);
    // SS still low from before reset: the frame below must be ignored
    spi_bits(8'h80, 8, r0);
    check("ss_low_oe", {31'd0, miso_oe}, 32'd0);
    spi_bits(8'h77, 8, r1);
    ss_end();
    check("ss_low_regs", regs, 32'h0);
    check("ss_low_stb", stb_cnt - stb0, 0);
    for (int k = 0; k < NREGS; k++) model_regs[k] = 8'h00;
    frame2(8'h80, 8'h77, r0, r1);
    model_regs[0] = 8'h77;
    check("postrst_reg0", {24'd0, regs[7:0]}, 32'h77);
    check("postrst_stb", stb_cnt - stb0, 1);
    $display("mid-frame reset: regs=%h", regs);

    // Randomized write/read pairs against the model
    for (int n = 0; n < 100; n++) begin
      a = 7'($urandom_range(0, NREGS - 1));
      d = 8'($urandom);
      frame2({1'b1, a}, d, r0, r1);
      model_regs[int'(a)] = d;
      frame2({1'b0, a}, 8'h00, r0, r1);
      check($sformatf("rand%0d_rd", n), {24'd0, r1}, {24'd0, model_read(a)});
      $display("rand %0d: addr=%0d wr=%h rd=%h", n, a, d, r1);
    end
    flat = 32'h0;
    for (int k = 0; k < NREGS; k++) flat[8*k +: 8] = model_regs[k];
    check("rand_regs", regs, flat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
